eff_sel_ctrl: RTL and testbench
===============================

# eff_sel_ctrl

Effect-selection sequencer between the board switches and the effects pipe, on the mclk domain. It debounces the raw effect-select vector and applies each change to the pipe as a fixed sequence: ramp the output down to silence, swap the select, flush the pipe, ramp back up. This removes clicks from reconfiguring the pipe mid-stream. The block drives `eff_pipe` sel/en and sits on the sample path between `eff_pipe` output and `i2s` tx input.

## Interface
- `SEL_W`, 16, width of effect-select vector
- `DEBOUNCE_CYC`, 250000, clk cycles sel_i must be stable before it is accepted (≥2)
- `RAMP_LOG2`, 8, ramp length is 2^RAMP_LOG2 samples each direction (≥1)
- `FLUSH_SAMPLES`, 16, zeroed samples emitted after swap while pipe settles (≥1)
- `clk` in 1: mclk
- `rst_n` in 1: synchronous, active-low reset
- `sel_i` in SEL_W: raw switch vector (asynchronous source; 2-FF synchronised internally)
- `sel_o` out SEL_W: applied effect select to eff_pipe
- `en_o` out 1: eff_pipe enable
- `data_i` in sample_t: post-effect sample from eff_pipe
- `vld_i` in 1: single-cycle strobe qualifying data_i
- `data_o` out sample_t: gain-scaled sample to i2s tx
- `vld_o` out 1: single-cycle strobe qualifying data_o
- `busy_o` out 1: high while a change sequence is in progress

## Operation
- Debounce: synchronised sel_i is compared with candidate register. On mismatch, load candidate and clear counter. Otherwise counter saturates at DEBOUNCE_CYC-1, and the candidate becomes the stable value `deb_sel`.
- Request: `deb_sel != sel_o` with counter saturated.
- Gain `g`: unsigned, RAMP_LOG2+1 bits, range 0..2^RAMP_LOG2.
- Output sample: signed product data_i*g, arithmetic right shift by RAMP_LOG2, truncated to sample_t. g=2^RAMP_LOG2 is exact passthrough; g=0 gives 0.
- Each vld_i produces exactly one vld_o in every state. There is no sample dropping.
- States:
  - RUN: g=2^RAMP_LOG2. On request, go to RAMP_DN.
  - RAMP_DN: each vld_i outputs with the current g, then g decrements. When an output has used g=1 (g becomes 0), go to SWAP.
  - SWAP: one cycle. sel_o ← current deb_sel. Go to FLUSH. A vld_i arriving this cycle outputs 0 and is not counted.
  - FLUSH: each vld_i outputs 0 and is counted. After FLUSH_SAMPLES, go to RAMP_UP.
  - RAMP_UP: each vld_i first increments g, then outputs with the new g. When g reaches 2^RAMP_LOG2, go to RUN.
- busy_o = (state != RUN). en_o = 1 in all states once out of reset.
- A sel_i change during a sequence does not abort it. SWAP loads the latest deb_sel; the next request is serviced on RUN re-entry.
- If deb_sel equals the old sel_o at SWAP, the sequence still completes.
- Reset values: state RUN, sel_o 0, en_o 0 during reset then 1, g 2^RAMP_LOG2, data_o 0, vld_o 0, busy_o 0, candidate 0, counter 0.
- Reset asserted mid-sequence returns every register to its reset value on the next edge. Any partial ramp is discarded.

## Timing
- data_o/vld_o are registered: vld_o is exactly 1 clk after vld_i. The multiply is combinational into that register.
- sel_i to request: 2 sync cycles + DEBOUNCE_CYC cycles of stability.
- sel_o updates on the SWAP→FLUSH edge.
- Minimum sequence length: 2^RAMP_LOG2 + FLUSH_SAMPLES + 2^RAMP_LOG2 input samples + 1 clk.
- vld_i strobes are spaced ≥2 clk apart (sample rate ≪ mclk). Back-to-back vld_i is still handled one per cycle.

## Structure
- sample_t comes from sample_pkg.
- The state enum and gain width are local to this module.
- Sub-module `sel_debounce`: 2-FF sync, candidate register and counter. Parameters SEL_W and DEBOUNCE_CYC; outputs deb_sel and stable.
- In top, this block sits between eff_pipe and i2s tx, with sel_i driven from SW.

## Test plan
Bench parameters: SAMPLE_W 24, DEBOUNCE_CYC 8, RAMP_LOG2 2, FLUSH_SAMPLES 2, vld_i every 4 clk, data_i constant 1000.
- Reset, sel_i=0, 20 samples → data_o all 1000, vld_o 1 clk after each vld_i, busy_o 0, sel_o 0, en_o 1.
- sel_i 0→0x0003 held → after sync+8 clk busy_o rises. Outputs are 1000, 750, 500, 250, then 0, 0 (flush). sel_o becomes 0x0003 before the first flush sample. Ramp up is 250, 500, 750, 1000, then busy_o 0.
- data_i = -1001 during a ramp with g=1 → data_o = -251 (arithmetic shift, floor).
- sel_i toggles every 5 clk for 40 clk, then rests at 0x0001 → no request during toggling; a single sequence follows, ending with sel_o 0x0001.
- sel_i changes to 0x0004 during RAMP_DN toward 0x0003 → SWAP loads 0x0004 if debounced by then, otherwise 0x0003 then a second sequence to 0x0004.
- rst_n low for 1 clk during FLUSH → next cycle state RUN, sel_o 0, g full, data_o/vld_o 0; the next sample passes at 1000.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared audio sample type for the effects path.
// Width is fixed board-wide; all stages import it from here.
package sample_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sel_debounce.sv
// Switch-vector debouncer: 2-FF sync, candidate register, stability counter.
// deb_sel only moves once a candidate has held for DEBOUNCE_CYC cycles.
module sel_debounce #(
  parameter int SEL_W        = 16,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel_i,
  output logic [SEL_W-1:0] deb_sel,
  output logic             stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_PRE =
    CNT_W'(DEBOUNCE_CYC - 2);

  logic [SEL_W-1:0] sync1;
  logic [SEL_W-1:0] sync2;
  logic [SEL_W-1:0] cand;
  logic [CNT_W-1:0] cnt;

  assign stable = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      cnt     <= '0;
      deb_sel <= '0;
    end else begin
      sync1 <= sel_i;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
        // publish on the same edge the counter saturates
        if (cnt == CNT_PRE) begin
          deb_sel <= cand;
        end
      end
    end
  end

endmodule

// File: rtl/eff_sel_ctrl.sv
// Effect-select sequencer: ramp down, swap select, flush, ramp up.
// Gain-scales the eff_pipe output so select changes are click-free.
module eff_sel_ctrl
  import sample_pkg::*;
#(
  parameter int SEL_W         = 16,
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int RAMP_LOG2     = 8,
  parameter int FLUSH_SAMPLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             en_o,
  input  sample_t          data_i,
  input  logic             vld_i,
  output sample_t          data_o,
  output logic             vld_o,
  output logic             busy_o
);

  localparam int G_W = RAMP_LOG2 + 1;
  localparam logic [G_W-1:0] G_FULL =
    {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [G_W-1:0] G_ONE = G_W'(1);
  localparam int F_W = $clog2(FLUSH_SAMPLES + 1);
  localparam logic [F_W-1:0] F_LAST =
    F_W'(FLUSH_SAMPLES - 1);
  localparam int P_W = SAMPLE_W + G_W + 1;

  typedef enum logic [2:0] {
    RUN,
    RAMP_DN,
    SWAP,
    FLUSH,
    RAMP_UP
  } state_t;

  state_t state;

  logic [G_W-1:0]   g;
  logic [G_W-1:0]   g_inc;
  logic [G_W-1:0]   g_use;
  logic [F_W-1:0]   fcnt;
  logic [SEL_W-1:0] deb_sel;
  logic             stable;
  logic             req;

  logic signed [P_W-1:0] prod;
  sample_t               scaled;

  sel_debounce #(
    .SEL_W        (SEL_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel_i   (sel_i),
    .deb_sel (deb_sel),
    .stable  (stable)
  );

  assign req   = stable && (deb_sel != sel_o);
  assign g_inc = g + G_ONE;

  // ramp-up applies the incremented gain to the same sample
  always_comb begin
    g_use = '0;
    unique case (state)
      RUN, RAMP_DN: g_use = g;
      RAMP_UP:      g_use = g_inc;
      default:      g_use = '0;
    endcase
  end

  assign prod = P_W'(data_i) *
                P_W'($signed({1'b0, g_use}));
  assign scaled = sample_t'(prod >>> RAMP_LOG2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      sel_o  <= '0;
      en_o   <= 1'b0;
      g      <= G_FULL;
      fcnt   <= '0;
      data_o <= '0;
      vld_o  <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      en_o  <= 1'b1;
      vld_o <= vld_i;
      if (vld_i) begin
        data_o <= scaled;
      end
      unique case (state)
        RUN: begin
          if (req) begin
            state  <= RAMP_DN;
            busy_o <= 1'b1;
          end
        end
        RAMP_DN: begin
          if (vld_i) begin
            g <= g - G_ONE;
            if (g == G_ONE) begin
              state <= SWAP;
            end
          end
        end
        SWAP: begin
          sel_o <= deb_sel;
          fcnt  <= '0;
          state <= FLUSH;
        end
        FLUSH: begin
          if (vld_i) begin
            fcnt <= fcnt + F_W'(1);
            if (fcnt == F_LAST) begin
              state <= RAMP_UP;
            end
          end
        end
        RAMP_UP: begin
          if (vld_i) begin
            g <= g_inc;
            if (g_inc == G_FULL) begin
              state  <= RUN;
              busy_o <= 1'b0;
            end
          end
        end
        default: begin
          state  <= RUN;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eff_sel_ctrl.sv
// Scoreboard bench for eff_sel_ctrl: directed vectors queue expected
// samples, an independent monitor pops them on each vld_o.
module tb_eff_sel_ctrl;
  import sample_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sel_i = '0;
  sample_t     data_i = '0;
  logic        vld_i = 1'b0;
  logic [15:0] sel_o;
  logic        en_o;
  sample_t     data_o;
  logic        vld_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  sample_t exp_q[$];
  sample_t mon_e;
  logic    vld_d = 1'b0;

  eff_sel_ctrl #(
    .SEL_W         (16),
    .DEBOUNCE_CYC  (8),
    .RAMP_LOG2     (2),
    .FLUSH_SAMPLES (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel_i  (sel_i),
    .sel_o  (sel_o),
    .en_o   (en_o),
    .data_i (data_i),
    .vld_i  (vld_i),
    .data_o (data_o),
    .vld_o  (vld_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) vld_d <= vld_i && rst_n;

  // monitor: timing of vld_o and value of data_o
  always @(negedge clk) begin
    if (vld_o || vld_d) begin
      checks++;
      if (vld_o !== vld_d) begin
        failures++;
        $display("FAIL vld_timing actual=%b required=%b",
                 vld_o, vld_d);
      end
    end
    if (vld_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL data_o_extra actual=%0d required=none",
                 data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (data_o !== mon_e) begin
          failures++;
          $display("FAIL data_o actual=%0d required=%0d",
                   data_o, mon_e);
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(sample_t d, sample_t e);
    data_i = d;
    vld_i  = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    vld_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ramp_up_tail();
    send(1000, 0);
    send(1000, 0);
    send(1000, 250);
    send(1000, 500);
    send(1000, 750);
    send(1000, 1000);
  endtask

  task automatic run_seq(logic [15:0] target, bit neg);
    idle(14);
    check("busy_rise", busy_o, 1);
    send(1000, 1000);
    send(1000, 750);
    send(1000, 500);
    if (neg) send(-1001, -251);
    else     send(1000, 250);
    check("sel_before_flush", sel_o, target);
    ramp_up_tail();
    check("busy_fall", busy_o, 0);
    check("sel_after", sel_o, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check("rst_sel_o", sel_o, 0);
    check("rst_en_o", en_o, 0);
    check("rst_busy_o", busy_o, 0);
    check("rst_vld_o", vld_o, 0);
    check("rst_data_o", data_o, 0);
    rst_n = 1'b1;
    idle(1);
    check("en_after_rst", en_o, 1);

    // steady run: passthrough
    for (int i = 0; i < 20; i++) send(1000, 1000);
    check("run_busy", busy_o, 0);
    check("run_sel", sel_o, 0);
    check("run_en", en_o, 1);

    // basic change 0 -> 3
    sel_i = 16'h0003;
    run_seq(16'h0003, 1'b0);

    // negative sample at g=1 floors
    sel_i = 16'h0002;
    run_seq(16'h0002, 1'b1);

    // bouncing switches never raise a request
    for (int i = 0; i < 8; i++) begin
      sel_i = i[0] ? 16'h00F0 : 16'h000F;
      idle(5);
      check("bounce_busy", busy_o, 0);
    end
    sel_i = 16'h0001;
    run_seq(16'h0001, 1'b0);
    idle(14);
    check("bounce_single_seq", busy_o, 0);

    // change arrives during ramp-down; swap takes the newer value
    sel_i = 16'h0003;
    idle(14);
    check("late_busy", busy_o, 1);
    sel_i = 16'h0004;
    send(1000, 1000);
    send(1000, 750);
    send(1000, 500);
    send(1000, 250);
    check("late_sel_swap", sel_o, 16'h0004);
    ramp_up_tail();
    check("late_busy_fall", busy_o, 0);
    idle(14);
    check("late_no_second", busy_o, 0);
    check("late_sel_final", sel_o, 16'h0004);

    // reset mid-flush discards the sequence
    sel_i = 16'h0008;
    idle(14);
    check("mid_busy", busy_o, 1);
    send(1000, 1000);
    send(1000, 750);
    send(1000, 500);
    send(1000, 250);
    send(1000, 0);
    rst_n = 1'b0;
    sel_i = 16'h0000;
    idle(1);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_sel", sel_o, 0);
    check("mid_rst_vld", vld_o, 0);
    check("mid_rst_data", data_o, 0);
    check("mid_rst_en", en_o, 0);
    rst_n = 1'b1;
    send(1000, 1000);
    idle(16);
    check("post_rst_busy", busy_o, 0);
    check("post_rst_en", en_o, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
